// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register slave: control/scratch/ID/status registers, write counter,
// and W1C interrupt status with enable mask driving a registered irq.
module axi4_lite_reg_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic [31:0] ID_VALUE   = 32'h4158_5531,
  parameter int          NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  axi4_lite_if.slave            axi,
  output logic [31:0]           ctrl_out,
  output logic                  ctrl_wr_pulse,
  input  logic [31:0]           status_in,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic                  irq,
  output logic [1:0]            dbg_state
);

  // Handshakes: a beat transfers on a rising clk edge where valid && ready are both 1;
  // the slave holds bvalid/bresp and rvalid/rdata/rresp stable until the matching ready.

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  localparam logic [11:0] OFF_CONTROL    = 12'h000;
  localparam logic [11:0] OFF_STATUS     = 12'h004;
  localparam logic [11:0] OFF_SCRATCH    = 12'h008;
  localparam logic [11:0] OFF_ID         = 12'h00C;
  localparam logic [11:0] OFF_WRITE_CNT  = 12'h010;
  localparam logic [11:0] OFF_IRQ_STATUS = 12'h014;
  localparam logic [11:0] OFF_IRQ_ENABLE = 12'h018;
  localparam logic [1:0]  RESP_OKAY      = 2'b00;
  localparam logic [1:0]  RESP_SLVERR    = 2'b10;
  localparam logic [31:0] EV_MASK = (NUM_EVENTS >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << NUM_EVENTS) - 32'd1);

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        ready_en_q;
  logic        aw_have_q, aw_have_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic        w_have_q, w_have_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic        ctrl_wr_pulse_q, ctrl_wr_pulse_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] wcount_q, wcount_d;
  logic [31:0] irq_status_q, irq_status_d;
  logic [31:0] irq_en_q, irq_en_d;
  logic        irq_q, irq_d;

  logic [31:0] ev_ext, wmask, w1c_clr, rd_val;
  logic        wr_ok, rd_ok;

  assign axi.awready   = ready_en_q && (w_state_q == W_IDLE) && !aw_have_q;
  assign axi.wready    = ready_en_q && (w_state_q == W_IDLE) && !w_have_q;
  assign axi.arready   = ready_en_q && (r_state_q == R_IDLE);
  assign axi.bvalid    = bvalid_q;
  assign axi.bresp     = bresp_q;
  assign axi.rvalid    = rvalid_q;
  assign axi.rdata     = rdata_q;
  assign axi.rresp     = rresp_q;
  assign ctrl_out      = ctrl_q;
  assign ctrl_wr_pulse = ctrl_wr_pulse_q;
  assign irq           = irq_q;
  assign dbg_state     = {w_state_q == W_RESP, r_state_q == R_DATA};

  always_comb begin
    ev_ext = '0;
    ev_ext[NUM_EVENTS-1:0] = event_in;
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{w_strb_q[i]}};
    wr_ok = (aw_addr_q[31:12] == BASE_ADDR[31:12]) && (aw_addr_q[1:0] == 2'b00) &&
            ((aw_addr_q[11:0] == OFF_CONTROL) || (aw_addr_q[11:0] == OFF_SCRATCH) ||
             (aw_addr_q[11:0] == OFF_IRQ_STATUS) || (aw_addr_q[11:0] == OFF_IRQ_ENABLE));
  end

  // Read decode sees pre-edge register values, so a same-edge write is not visible.
  always_comb begin
    rd_ok  = (axi.araddr[31:12] == BASE_ADDR[31:12]) && (axi.araddr[1:0] == 2'b00);
    rd_val = '0;
    case (axi.araddr[11:0])
      OFF_CONTROL:    rd_val = ctrl_q;
      OFF_STATUS:     rd_val = status_in;
      OFF_SCRATCH:    rd_val = scratch_q;
      OFF_ID:         rd_val = ID_VALUE;
      OFF_WRITE_CNT:  rd_val = wcount_q;
      OFF_IRQ_STATUS: rd_val = irq_status_q;
      OFF_IRQ_ENABLE: rd_val = irq_en_q;
      default:        rd_ok  = 1'b0;
    endcase
    if (!rd_ok) rd_val = '0;
  end

  always_comb begin
    w_state_d       = w_state_q;
    aw_have_d       = aw_have_q;
    aw_addr_d       = aw_addr_q;
    w_have_d        = w_have_q;
    w_data_d        = w_data_q;
    w_strb_d        = w_strb_q;
    bvalid_d        = bvalid_q;
    bresp_d         = bresp_q;
    ctrl_d          = ctrl_q;
    ctrl_wr_pulse_d = 1'b0;
    scratch_d       = scratch_q;
    wcount_d        = wcount_q;
    irq_en_d        = irq_en_q;
    w1c_clr         = '0;

    if (axi.awvalid && axi.awready) begin
      aw_have_d = 1'b1;
      aw_addr_d = axi.awaddr;
    end
    if (axi.wvalid && axi.wready) begin
      w_have_d = 1'b1;
      w_data_d = axi.wdata;
      w_strb_d = axi.wstrb;
    end

    case (w_state_q)
      W_IDLE: begin
        if (aw_have_q && w_have_q) begin
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
          if (wr_ok) begin
            wcount_d = wcount_q + 32'd1;
            case (aw_addr_q[11:0])
              OFF_CONTROL: begin
                ctrl_d          = (ctrl_q & ~wmask) | (w_data_q & wmask);
                ctrl_wr_pulse_d = 1'b1;
              end
              OFF_SCRATCH:    scratch_d = (scratch_q & ~wmask) | (w_data_q & wmask);
              OFF_IRQ_STATUS: w1c_clr   = w_data_q & wmask;
              OFF_IRQ_ENABLE: irq_en_d  = ((irq_en_q & ~wmask) | (w_data_q & wmask)) & EV_MASK;
              default: ;
            endcase
          end
        end
      end
      W_RESP: begin
        if (axi.bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    // Event set is applied after the clear so a coincident pulse keeps the bit set.
    irq_status_d = ((irq_status_q & ~w1c_clr) | ev_ext) & EV_MASK;
    irq_d        = |(irq_status_q & irq_en_q);
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi.arvalid && axi.arready) begin
          rvalid_d  = 1'b1;
          rdata_d   = rd_val;
          rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi.rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q       <= W_IDLE;
      r_state_q       <= R_IDLE;
      ready_en_q      <= 1'b0;
      aw_have_q       <= 1'b0;
      aw_addr_q       <= '0;
      w_have_q        <= 1'b0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      bvalid_q        <= 1'b0;
      bresp_q         <= '0;
      rvalid_q        <= 1'b0;
      rdata_q         <= '0;
      rresp_q         <= '0;
      ctrl_q          <= '0;
      ctrl_wr_pulse_q <= 1'b0;
      scratch_q       <= '0;
      wcount_q        <= '0;
      irq_status_q    <= '0;
      irq_en_q        <= '0;
      irq_q           <= 1'b0;
    end else begin
      w_state_q       <= w_state_d;
      r_state_q       <= r_state_d;
      ready_en_q      <= 1'b1;
      aw_have_q       <= aw_have_d;
      aw_addr_q       <= aw_addr_d;
      w_have_q        <= w_have_d;
      w_data_q        <= w_data_d;
      w_strb_q        <= w_strb_d;
      bvalid_q        <= bvalid_d;
      bresp_q         <= bresp_d;
      rvalid_q        <= rvalid_d;
      rdata_q         <= rdata_d;
      rresp_q         <= rresp_d;
      ctrl_q          <= ctrl_d;
      ctrl_wr_pulse_q <= ctrl_wr_pulse_d;
      scratch_q       <= scratch_d;
      wcount_q        <= wcount_d;
      irq_status_q    <= irq_status_d;
      irq_en_q        <= irq_en_d;
      irq_q           <= irq_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave: register-map vector table plus
// hand-timed sequences for channel ordering, W1C races, irq lag and reset abort.
module tb_axi4_lite_reg_slave;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] STATUS = 32'hCAFE_F00D;
  localparam int          TMO    = 50;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl_out;
  logic        ctrl_wr_pulse;
  logic [31:0] status_in;
  logic [7:0]  event_in;
  logic        irq;
  logic [1:0]  dbg_state;

  axi4_lite_if axi_bus ();

  axi4_lite_reg_slave #(
    .BASE_ADDR  (BASE),
    .ID_VALUE   (32'h4158_5531),
    .NUM_EVENTS (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .axi           (axi_bus),
    .ctrl_out      (ctrl_out),
    .ctrl_wr_pulse (ctrl_wr_pulse),
    .status_in     (status_in),
    .event_in      (event_in),
    .irq           (irq),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no handshake within %0d cycles", name, TMO);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_w(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s,
                       input logic [1:0] r);
    vec_t v;
    v = '{1'b1, BASE + off, d, s, r, 32'h0};
    vq.push_back(v);
  endtask

  task automatic add_r(input logic [31:0] off, input logic [1:0] r, input logic [31:0] d);
    vec_t v;
    v = '{1'b0, BASE + off, 32'h0, 4'h0, r, d};
    vq.push_back(v);
  endtask

  // driver tasks
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    axi_bus.awaddr  = addr;
    axi_bus.awvalid = 1'b1;
    axi_bus.wdata   = data;
    axi_bus.wstrb   = strb;
    axi_bus.wvalid  = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    resp    = 2'b11;
    lat     = -1;
    while (!(aw_done && w_done) && cyc < TMO) begin
      aw_hs = axi_bus.awvalid && axi_bus.awready;
      w_hs  = axi_bus.wvalid && axi_bus.wready;
      tick();
      cyc++;
      if (aw_hs) begin aw_done = 1'b1; axi_bus.awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; axi_bus.wvalid  = 1'b0; end
    end
    axi_bus.awvalid = 1'b0;
    axi_bus.wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin
      fail_timeout("write_accept");
      return;
    end
    cyc = 0;
    while (!axi_bus.bvalid && cyc < TMO) begin tick(); cyc++; end
    if (!axi_bus.bvalid) begin
      fail_timeout("bvalid_wait");
      return;
    end
    lat  = cyc;
    resp = axi_bus.bresp;
    axi_bus.bready = 1'b1;
    tick();
    axi_bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    bit hs, done;
    int cyc;
    axi_bus.araddr  = addr;
    axi_bus.arvalid = 1'b1;
    done = 1'b0;
    cyc  = 0;
    data = 32'hX;
    resp = 2'b11;
    lat  = -1;
    while (!done && cyc < TMO) begin
      hs = axi_bus.arvalid && axi_bus.arready;
      tick();
      cyc++;
      if (hs) done = 1'b1;
    end
    axi_bus.arvalid = 1'b0;
    if (!done) begin
      fail_timeout("read_accept");
      return;
    end
    cyc = 0;
    while (!axi_bus.rvalid && cyc < TMO) begin tick(); cyc++; end
    if (!axi_bus.rvalid) begin
      fail_timeout("rvalid_wait");
      return;
    end
    lat  = cyc;
    data = axi_bus.rdata;
    resp = axi_bus.rresp;
    axi_bus.rready = 1'b1;
    tick();
    axi_bus.rready = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    int          l;
    axi_read(BASE + off, d, r, l);
    check({name, "_rresp"}, 32'(r), 32'h0);
    check({name, "_rdata"}, d, exp);
  endtask

  task automatic wr_check(input string name, input logic [31:0] off, input logic [31:0] d,
                          input logic [3:0] s);
    logic [1:0] r;
    int         l;
    axi_write(BASE + off, d, s, r, l);
    check({name, "_bresp"}, 32'(r), 32'h0);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_awready"}, 32'(axi_bus.awready), 32'h0);
    check({pfx, "_wready"},  32'(axi_bus.wready),  32'h0);
    check({pfx, "_arready"}, 32'(axi_bus.arready), 32'h0);
    check({pfx, "_bvalid"},  32'(axi_bus.bvalid),  32'h0);
    check({pfx, "_rvalid"},  32'(axi_bus.rvalid),  32'h0);
    check({pfx, "_bresp"},   32'(axi_bus.bresp),   32'h0);
    check({pfx, "_rresp"},   32'(axi_bus.rresp),   32'h0);
    check({pfx, "_rdata"},   axi_bus.rdata,        32'h0);
    check({pfx, "_ctrl"},    ctrl_out,             32'h0);
    check({pfx, "_pulse"},   32'(ctrl_wr_pulse),   32'h0);
    check({pfx, "_irq"},     32'(irq),             32'h0);
    check({pfx, "_dbg"},     32'(dbg_state),       32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          l;
    int          held;
    int          pulses;

    rst             = 1'b0;
    status_in       = STATUS;
    event_in        = 8'h00;
    axi_bus.awaddr  = '0;
    axi_bus.awvalid = 1'b0;
    axi_bus.wdata   = '0;
    axi_bus.wstrb   = '0;
    axi_bus.wvalid  = 1'b0;
    axi_bus.bready  = 1'b0;
    axi_bus.araddr  = '0;
    axi_bus.arvalid = 1'b0;
    axi_bus.rready  = 1'b0;

    // reset state
    repeat (3) tick();
    check_idle_outputs("in_reset");
    rst = 1'b1;
    check("ready_before_clk", 32'(axi_bus.awready), 32'h0);
    tick();
    check("ready_after_clk", 32'({axi_bus.awready, axi_bus.wready, axi_bus.arready}), 32'h7);

    // register-map vectors: running WRITE_COUNT noted on counting writes
    add_w(32'h08, 32'hDEAD_BEEF, 4'hF, 2'b00);       // 1
    add_r(32'h08, 2'b00, 32'hDEAD_BEEF);
    add_r(32'h10, 2'b00, 32'h1);
    add_r(32'h0C, 2'b00, 32'h4158_5531);
    add_w(32'h04, 32'h0000_0001, 4'hF, 2'b10);
    add_r(32'h10, 2'b00, 32'h1);
    add_r(32'h04, 2'b00, STATUS);
    add_r(32'h02, 2'b10, 32'h0);
    add_r(32'h1C, 2'b10, 32'h0);
    add_r(32'h1008, 2'b10, 32'h0);
    add_w(32'h1008, 32'h1234_5678, 4'hF, 2'b10);
    add_r(32'h10, 2'b00, 32'h1);
    add_w(32'h08, 32'hA5A5_A5A5, 4'b0010, 2'b00);    // 2
    add_r(32'h08, 2'b00, 32'hDEAD_A5EF);
    add_w(32'h08, 32'hFFFF_FFFF, 4'h0, 2'b00);       // 3
    add_r(32'h08, 2'b00, 32'hDEAD_A5EF);
    add_r(32'h10, 2'b00, 32'h3);
    add_w(32'h18, 32'hFFFF_FFFF, 4'hF, 2'b00);       // 4
    add_r(32'h18, 2'b00, 32'h0000_00FF);
    add_w(32'h18, 32'h0000_0000, 4'hF, 2'b00);       // 5
    add_r(32'h18, 2'b00, 32'h0);
    add_w(32'h0C, 32'h1111_1111, 4'hF, 2'b10);
    add_w(32'h0A, 32'h1111_1111, 4'hF, 2'b10);
    add_w(32'h10, 32'h0000_0000, 4'hF, 2'b10);
    add_w(32'h1C, 32'h0000_0000, 4'hF, 2'b10);
    add_r(32'h14, 2'b00, 32'h0);
    add_r(32'h00, 2'b00, 32'h0);
    add_r(32'h10, 2'b00, 32'h5);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].is_wr) begin
        axi_write(vq[i].addr, vq[i].wdata, vq[i].wstrb, r, l);
        check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vq[i].exp_resp));
        check($sformatf("vec%0d_b_latency", i), 32'(l), 32'd1);
      end else begin
        axi_read(vq[i].addr, d, r, l);
        check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vq[i].exp_resp));
        check($sformatf("vec%0d_rdata", i), d, vq[i].exp_rdata);
        check($sformatf("vec%0d_r_latency", i), 32'(l), 32'd0);
      end
    end

    // W three cycles ahead of AW to CONTROL, then a stalled B channel
    axi_bus.wdata  = 32'h1234_5678;
    axi_bus.wstrb  = 4'b0101;
    axi_bus.wvalid = 1'b1;
    check("early_w_wready", 32'(axi_bus.wready), 32'h1);
    tick();
    axi_bus.wvalid = 1'b0;
    check("early_w_latched", 32'({axi_bus.wready, axi_bus.awready}), 32'h1);
    repeat (2) tick();
    axi_bus.awaddr  = BASE + 32'h00;
    axi_bus.awvalid = 1'b1;
    tick();
    axi_bus.awvalid = 1'b0;
    check("early_w_no_b_yet", 32'({axi_bus.bvalid, ctrl_wr_pulse}), 32'h0);
    tick();
    check("early_w_bvalid", 32'(axi_bus.bvalid), 32'h1);
    check("early_w_bresp", 32'(axi_bus.bresp), 32'h0);
    check("early_w_pulse", 32'(ctrl_wr_pulse), 32'h1);
    check("early_w_ctrl", ctrl_out, 32'h0034_0078);
    held   = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (axi_bus.bvalid && axi_bus.bresp == 2'b00) held++;
      if (ctrl_wr_pulse) pulses++;
    end
    check("b_stall_held", 32'(held), 32'd5);
    check("b_stall_pulses", 32'(pulses), 32'd0);
    check("b_stall_dbg", 32'(dbg_state), 32'h2);
    check("b_stall_no_accept", 32'({axi_bus.awready, axi_bus.wready}), 32'h0);
    axi_bus.bready = 1'b1;
    tick();
    axi_bus.bready = 1'b0;
    check("b_release", 32'(axi_bus.bvalid), 32'h0);
    rd_check("ctrl_rb", 32'h00, 32'h0034_0078);                         // count 6

    // read of SCRATCH lands on the same edge as the write commit
    axi_bus.awaddr  = BASE + 32'h08;
    axi_bus.wdata   = 32'h1111_1111;
    axi_bus.wstrb   = 4'hF;
    axi_bus.awvalid = 1'b1;
    axi_bus.wvalid  = 1'b1;
    tick();
    axi_bus.awvalid = 1'b0;
    axi_bus.wvalid  = 1'b0;
    axi_bus.araddr  = BASE + 32'h08;
    axi_bus.arvalid = 1'b1;
    check("race_arready", 32'(axi_bus.arready), 32'h1);
    tick();
    axi_bus.arvalid = 1'b0;
    check("race_bvalid", 32'(axi_bus.bvalid), 32'h1);
    check("race_rvalid", 32'(axi_bus.rvalid), 32'h1);
    check("race_rdata_old", axi_bus.rdata, 32'hDEAD_A5EF);
    axi_bus.bready = 1'b1;
    axi_bus.rready = 1'b1;
    tick();
    axi_bus.bready = 1'b0;
    axi_bus.rready = 1'b0;
    check("race_released", 32'({axi_bus.bvalid, axi_bus.rvalid}), 32'h0);
    rd_check("race_new", 32'h08, 32'h1111_1111);                        // count 7

    // interrupts
    wr_check("irq_en5", 32'h18, 32'h0000_0005, 4'hF);                  // count 8
    event_in = 8'h03;
    tick();
    event_in = 8'h00;
    check("irq_lag", 32'(irq), 32'h0);
    tick();
    check("irq_set", 32'(irq), 32'h1);
    rd_check("irq_st3", 32'h14, 32'h3);

    axi_bus.awaddr  = BASE + 32'h14;
    axi_bus.wdata   = 32'h0000_0001;
    axi_bus.wstrb   = 4'hF;
    axi_bus.awvalid = 1'b1;
    axi_bus.wvalid  = 1'b1;
    tick();
    axi_bus.awvalid = 1'b0;
    axi_bus.wvalid  = 1'b0;
    event_in = 8'h01;
    tick();
    event_in = 8'h00;
    check("w1c_race_bvalid", 32'(axi_bus.bvalid), 32'h1);
    axi_bus.bready = 1'b1;
    tick();
    axi_bus.bready = 1'b0;
    rd_check("w1c_race_set_wins", 32'h14, 32'h3);                       // count 9
    check("w1c_race_irq", 32'(irq), 32'h1);

    wr_check("w1c_clr0", 32'h14, 32'h0000_0001, 4'hF);                 // count 10
    check("irq_cleared", 32'(irq), 32'h0);
    rd_check("irq_st2", 32'h14, 32'h2);
    wr_check("w1c_nostrb", 32'h14, 32'h0000_0002, 4'h0);               // count 11
    rd_check("irq_st2_kept", 32'h14, 32'h2);
    wr_check("irq_en7", 32'h18, 32'h0000_0007, 4'hF);                  // count 12
    check("irq_en7_irq", 32'(irq), 32'h1);
    rd_check("wcount12", 32'h10, 32'h0000_000C);

    // reset while B and R responses are both pending
    axi_bus.awaddr  = BASE + 32'h08;
    axi_bus.wdata   = 32'h0000_0077;
    axi_bus.wstrb   = 4'hF;
    axi_bus.araddr  = BASE + 32'h0C;
    axi_bus.awvalid = 1'b1;
    axi_bus.wvalid  = 1'b1;
    axi_bus.arvalid = 1'b1;
    tick();
    axi_bus.awvalid = 1'b0;
    axi_bus.wvalid  = 1'b0;
    axi_bus.arvalid = 1'b0;
    tick();
    check("pre_rst_pending", 32'({axi_bus.bvalid, axi_bus.rvalid}), 32'h3);
    #1;
    rst = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("post_rst_ready", 32'({axi_bus.awready, axi_bus.wready, axi_bus.arready}), 32'h7);
    check("post_rst_no_resp", 32'({axi_bus.bvalid, axi_bus.rvalid}), 32'h0);
    rd_check("post_rst_ctrl", 32'h00, 32'h0);
    rd_check("post_rst_scratch", 32'h08, 32'h0);
    rd_check("post_rst_wcount", 32'h10, 32'h0);
    rd_check("post_rst_irqst", 32'h14, 32'h0);
    rd_check("post_rst_irqen", 32'h18, 32'h0);
    wr_check("post_rst_wr", 32'h08, 32'h5A5A_5A5A, 4'hF);
    rd_check("post_rst_rb", 32'h08, 32'h5A5A_5A5A);
    rd_check("post_rst_wcount1", 32'h10, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_reg_slave.md
Name: axi4_lite_reg_slave

Overview:
- AXI4-Lite responder (slave) register block that terminates the transactions issued by the UART-AXI4-Lite bridge master.
- Provides control, scratch and ID registers, live status sampling, a write counter, and a W1C interrupt status/enable pair with a level IRQ output.
- Sits on the bridge's AXI4-Lite bus as the first on-chip target. It is the board bring-up endpoint for UART register access.

Parameters:
- BASE_ADDR, 32'h0000_1000, base of the 4 KiB register window; must be 4 KiB aligned.
- ID_VALUE, 32'h4158_5531, constant returned by the ID register.
- NUM_EVENTS, 8, number of interrupt event inputs (1..32).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset; all state clears while rst=0.
- axi  interface  axi4_lite_if.slave  AXI4-Lite slave side: awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready.
- ctrl_out  output  32  CONTROL register contents.
- ctrl_wr_pulse  output  1  one-cycle pulse when CONTROL is successfully written.
- status_in  input  32  live status, readable via STATUS.
- event_in  input  NUM_EVENTS  single-cycle event pulses; each pulse sets the matching IRQ_STATUS bit.
- irq  output  1  registered OR of (IRQ_STATUS & IRQ_ENABLE).

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x00 CONTROL: RW, reset 0.
  - 0x04 STATUS: RO, returns status_in sampled at the AR handshake.
  - 0x08 SCRATCH: RW, reset 0.
  - 0x0C ID: RO, returns ID_VALUE.
  - 0x10 WRITE_COUNT: RO, reset 0; increments by 1 on every OKAY write; wraps 0xFFFF_FFFF to 0.
  - 0x14 IRQ_STATUS: W1C, reset 0; bits above NUM_EVENTS read 0.
  - 0x18 IRQ_ENABLE: RW, reset 0; bits above NUM_EVENTS are ignored on write and read 0.
- Responses:
  - OKAY is 2'b00.
  - SLVERR is 2'b10 for all of the following: address outside the 4 KiB window, addr[1:0]!=0, unmapped offset, or write to an RO register.
  - An erroring write has no side effects and does not increment WRITE_COUNT.
  - An erroring read returns rdata=0.
- WSTRB: byte lane i updates bits [8i+7:8i] of RW registers. For IRQ_STATUS, a bit clears only if its wdata bit is 1 and its lane strobe is 1. A write with wstrb=0 is OKAY, changes nothing, and still counts.
- Write channel FSM, states W_IDLE and W_RESP:
  - In W_IDLE, awready=1 until an AW is latched and wready=1 until a W is latched. AW and W are accepted in either order or in the same cycle.
  - When both are latched at edge T, the register update, WRITE_COUNT increment and ctrl_wr_pulse all occur at edge T+1. bvalid rises at T+1 with bresp; the FSM enters W_RESP.
  - In W_RESP, awready=wready=0 and bvalid/bresp are held stable until bready=1. The FSM then returns to W_IDLE, with bvalid low on the next cycle.
  - Minimum AW-to-B latency is 1 cycle.
- Read channel FSM, states R_IDLE and R_DATA:
  - In R_IDLE, arready=1. An AR handshake at edge T latches rdata/rresp; rvalid=1 from T+1.
  - In R_DATA, arready=0 and rvalid/rdata/rresp are held until rready. The FSM then returns to R_IDLE.
  - Reads have no side effects.
- The read and write channels are independent. A read and a write to the same register completing in the same cycle: the read returns the pre-write value.
- IRQ_STATUS and irq:
  - An event_in[i] pulse sets bit i.
  - If an event pulse and a W1C clear for the same bit land in the same cycle, set wins.
  - irq = registered OR of (IRQ_STATUS & IRQ_ENABLE), so it lags a status or enable change by 1 cycle.
- Reset values: all outputs 0 during and after reset. This covers awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, ctrl_out, ctrl_wr_pulse and irq. Ready signals rise on the first clk after rst deasserts.
- Reset mid-transaction: all latched AW/W/AR state and pending B/R responses are discarded. The master sees no response for the aborted transaction.

Test Plan:
- Write 0xDEADBEEF to BASE+0x08 (AW and W in the same cycle, wstrb=4'hF), then read it back -> bresp=00, bvalid at T+1; rdata=0xDEADBEEF with rresp=00; WRITE_COUNT reads 1.
- W issued 3 cycles before AW to BASE+0x00 with wdata=0x12345678 and wstrb=4'b0101 -> ctrl_out=0x00340078; ctrl_wr_pulse high for exactly 1 cycle; bvalid held for 5 cycles while bready=0.
- Read BASE+0x0C -> 0x41585531. Write to BASE+0x04 -> SLVERR, WRITE_COUNT unchanged. Read BASE+0x02 (misaligned) and BASE+0x1C (unmapped) -> SLVERR with rdata=0.
- Set IRQ_ENABLE=0x05, pulse event_in[0] and event_in[1] -> IRQ_STATUS=0x03, irq=1 one cycle later. Write 0x01 to IRQ_STATUS in the same cycle as a new event_in[0] pulse -> bit 0 stays 1. A later clear with no event -> IRQ_STATUS=0x02, irq=0.
- Pull rst low while bvalid=1 and rready is stalled -> bvalid=rvalid=0 immediately. After release, all registers read their reset values and a new write completes normally.
